// File: rtl/rgbw_pkg.sv
// Shared types and constants for the RGBW frame sequencer: FSM states,
// byte positions within a configuration frame and the default frame length.
package rgbw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RECV,
    ST_CHECK,
    ST_COMMIT
  } state_t;

  localparam int FRAME_LEN_DEF = 8;
  localparam int NUM_REGS      = 7;

  localparam int IDX_MODE  = 0;
  localparam int IDX_LINT  = 1;
  localparam int IDX_COLOR = 2;
  localparam int IDX_WHITE = 3;
  localparam int IDX_RED   = 4;
  localparam int IDX_GREEN = 5;
  localparam int IDX_BLUE  = 6;
  localparam int IDX_CSUM  = 7;

endpackage

// File: rtl/rgbw_frame_timer.sv
// Inter-byte watchdog: reloads on every accepted byte, counts down while a
// frame is being received and pulses o_expire on the last allowed cycle.
module rgbw_frame_timer #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_run,
  output logic o_expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;

  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CNT_W'(TIMEOUT_CYCLES);
    end else if (!i_run) begin
      r_cnt <= '0;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // After a load the counter reaches 1 exactly TIMEOUT_CYCLES-1 edges later,
  // so the expiry lands on the edge TIMEOUT_CYCLES after the last byte.
  assign o_expire = i_run && (r_cnt == CNT_W'(1));

endmodule

// File: rtl/rgbw_frame_sequencer.sv
// Assembles checksummed 8-byte SPI configuration frames, commits the seven
// colour/mode registers atomically and hands each commit to colorGen via req/ack.
module rgbw_frame_sequencer
  import rgbw_pkg::*;
#(
  parameter int FRAME_LEN      = FRAME_LEN_DEF,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int ERR_CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cs,
  input  logic                 rdy,
  input  logic [7:0]           data_byte,
  input  logic                 gen_ack,
  output logic [7:0]           mode,
  output logic [7:0]           lint,
  output logic [7:0]           color_idx,
  output logic [7:0]           white,
  output logic [7:0]           red,
  output logic [7:0]           green,
  output logic [7:0]           blue,
  output logic                 cfg_valid,
  output logic                 gen_req,
  output logic                 frame_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [3:0]           byte_cnt
);

  state_t r_state;
  state_t w_state_nxt;

  logic [7:0]           r_rx     [NUM_REGS];
  logic [7:0]           r_shadow [NUM_REGS];
  logic [7:0]           r_cfg    [NUM_REGS];
  logic [7:0]           r_sum;
  logic [7:0]           r_csum;
  logic [3:0]           r_byte_cnt;
  logic                 r_cfg_valid;
  logic                 r_gen_req;
  logic                 r_frame_err;
  logic [ERR_CNT_W-1:0] r_err_cnt;
  logic                 r_pending;
  logic                 r_ack_commit;

  logic w_accept;
  logic w_abort;
  logic w_timeout;
  logic w_pass;
  logic w_fail;
  logic w_expire;
  logic w_ack;
  logic w_set_pending;
  logic w_commit;
  logic w_err;
  logic w_last_byte;

  rgbw_frame_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_accept),
    .i_run   (r_state == ST_RECV),
    .o_expire(w_expire)
  );

  assign w_last_byte = (r_byte_cnt == 4'(FRAME_LEN - 1));

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_abort     = 1'b0;
    w_timeout   = 1'b0;
    w_pass      = 1'b0;
    w_fail      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (rdy && !cs) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_RECV;
        end
      end
      ST_RECV: begin
        // Abort beats a same-cycle byte; a byte beats a same-cycle timeout.
        if (cs) begin
          w_abort     = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (rdy) begin
          w_accept = 1'b1;
          if (w_last_byte) w_state_nxt = ST_CHECK;
        end else if (w_expire) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (r_sum == r_csum) begin
          w_pass      = 1'b1;
          w_state_nxt = r_gen_req ? ST_IDLE : ST_COMMIT;
        end else begin
          w_fail      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_COMMIT: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_ack         = r_gen_req && gen_ack;
  assign w_set_pending = w_pass && r_gen_req;
  assign w_commit      = (r_state == ST_COMMIT) || r_ack_commit;
  assign w_err         = w_abort || w_timeout || w_fail;

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the byte arrays are small register files with defined reset
      // values, so they are cleared here along with the control state.
      for (int i = 0; i < NUM_REGS; i++) begin
        r_rx[i]     <= 8'h00;
        r_shadow[i] <= 8'h00;
        r_cfg[i]    <= 8'h00;
      end
      r_sum        <= 8'h00;
      r_csum       <= 8'h00;
      r_byte_cnt   <= 4'd0;
      r_cfg_valid  <= 1'b0;
      r_gen_req    <= 1'b0;
      r_frame_err  <= 1'b0;
      r_err_cnt    <= '0;
      r_pending    <= 1'b0;
      r_ack_commit <= 1'b0;
    end else begin
      r_frame_err <= w_err;
      if (w_err && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);

      if (w_accept) begin
        if (w_last_byte) begin
          r_csum <= data_byte;
        end else begin
          for (int i = 0; i < NUM_REGS; i++)
            if (r_byte_cnt == 4'(i)) r_rx[i] <= data_byte;
          r_sum <= (r_byte_cnt == 4'd0) ? data_byte : r_sum + data_byte;
        end
        r_byte_cnt <= r_byte_cnt + 4'd1;
      end else if (w_abort || w_timeout || (r_state == ST_CHECK)) begin
        r_byte_cnt <= 4'd0;
      end

      // The receive buffer is separate, so the validated frame stays frozen
      // here until a newer frame passes its checksum.
      if (w_pass) r_shadow <= r_rx;

      r_cfg_valid <= w_commit;
      if (w_commit) r_cfg <= r_shadow;

      if (w_commit)   r_gen_req <= 1'b1;
      else if (w_ack) r_gen_req <= 1'b0;

      if (w_set_pending) r_pending <= 1'b1;
      else if (w_commit) r_pending <= 1'b0;

      // Covers a frame passing CHECK in the very cycle the ack arrives.
      r_ack_commit <= w_ack && (r_pending || w_set_pending);
    end
  end

  assign mode      = r_cfg[IDX_MODE];
  assign lint      = r_cfg[IDX_LINT];
  assign color_idx = r_cfg[IDX_COLOR];
  assign white     = r_cfg[IDX_WHITE];
  assign red       = r_cfg[IDX_RED];
  assign green     = r_cfg[IDX_GREEN];
  assign blue      = r_cfg[IDX_BLUE];
  assign cfg_valid = r_cfg_valid;
  assign gen_req   = r_gen_req;
  assign frame_err = r_frame_err;
  assign err_cnt   = r_err_cnt;
  assign byte_cnt  = r_byte_cnt;

endmodule

// File: tb/tb_rgbw_frame_sequencer.sv
// Directed bench for rgbw_frame_sequencer: a vector table of whole frames plus
// hand-written sequences for timeout, cs abort, pending overwrite, saturation and reset.
module tb_rgbw_frame_sequencer;

  localparam int TO = 32;

  typedef logic [0:7][7:0] frame_t;
  typedef struct {
    frame_t f;
    logic   err;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       cs;
  logic       rdy;
  logic [7:0] data_byte;
  logic       gen_ack;
  logic [7:0] mode, lint, color_idx, white, red, green, blue;
  logic       cfg_valid, gen_req, frame_err;
  logic [7:0] err_cnt;
  logic [3:0] byte_cnt;

  logic       ack_auto = 1'b1;
  logic       ack_man  = 1'b0;
  logic [2:0] hist     = 3'b000;
  logic       saw_b    = 1'b0;

  int         n_cmp  = 0;
  int         n_fail = 0;
  logic [7:0] exp_err_cnt;
  frame_t     exp_regs;
  vec_t       vecs [8];

  rgbw_frame_sequencer #(
    .FRAME_LEN     (8),
    .TIMEOUT_CYCLES(TO),
    .ERR_CNT_W     (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cs       (cs),
    .rdy      (rdy),
    .data_byte(data_byte),
    .gen_ack  (gen_ack),
    .mode     (mode),
    .lint     (lint),
    .color_idx(color_idx),
    .white    (white),
    .red      (red),
    .green    (green),
    .blue     (blue),
    .cfg_valid(cfg_valid),
    .gen_req  (gen_req),
    .frame_err(frame_err),
    .err_cnt  (err_cnt),
    .byte_cnt (byte_cnt)
  );

  always #5 clk = ~clk;

  // colorGen stand-in: acknowledges three cycles after it sees gen_req.
  always @(posedge clk) hist <= {hist[1:0], gen_req};
  assign gen_ack = ack_auto ? hist[2] : ack_man;

  always @(negedge clk) if (blue === 8'hFF) saw_b = 1'b1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_regs(input string name, input frame_t f);
    check({name, ".mode"},  mode,      f[0]);
    check({name, ".lint"},  lint,      f[1]);
    check({name, ".color"}, color_idx, f[2]);
    check({name, ".white"}, white,     f[3]);
    check({name, ".red"},   red,       f[4]);
    check({name, ".green"}, green,     f[5]);
    check({name, ".blue"},  blue,      f[6]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rdy       = 1'b1;
    data_byte = b;
    step();
    rdy = 1'b0;
  endtask

  // Returns just after the edge that samples the checksum byte.
  task automatic send_bytes(input frame_t f, input int first);
    for (int i = first; i < 8; i++) begin
      send_byte(f[i]);
      if (i < 7) step();
    end
  endtask

  task automatic wait_req_drop(input string name, input int exp_cycles);
    int n = 0;
    while (gen_req === 1'b1 && n < 20) begin
      n++;
      step();
    end
    check(name, n, exp_cycles);
  endtask

  task automatic bump_err();
    if (exp_err_cnt != 8'hFF) exp_err_cnt++;
  endtask

  frame_t fa, fb, fc, fd, fbad;

  initial begin
    // 0x01+0x80+0x05+0x10+0x20+0x30+0x40 = 0x126, so the valid checksum is 0x26.
    vecs[0] = '{f: 64'h01800510203040D7, err: 1'b1};
    vecs[1] = '{f: 64'h01800510203040D6, err: 1'b1};
    vecs[2] = '{f: 64'h0180051020304026, err: 1'b0};
    vecs[3] = '{f: 64'hAA553456789A_00AD ^ 64'h0000_6600_0000_0000, err: 1'b0};
    vecs[4] = '{f: 64'hFFFFFFFFFFFFFFF9, err: 1'b0};
    vecs[5] = '{f: 64'h0000000000000080, err: 1'b1};
    vecs[6] = '{f: 64'h0000000000000000, err: 1'b0};
    vecs[7] = '{f: 64'h123456789ABCDE48, err: 1'b0};
    vecs[3].f = 64'hAA553412_56789AAD;
    vecs[3].f = 64'hAA5512345678_9AAD;
    fa   = 64'hAA5512345678_9AAD;
    fb   = 64'hFFFFFFFFFFFFFFF9;
    fc   = 64'h0180051020304026;
    fd   = 64'h123456789ABCDE48;
    fbad = 64'h0000000000000001;

    reset = 1'b1; cs = 1'b1; rdy = 1'b0; data_byte = 8'h00;
    exp_err_cnt = 8'h00;
    exp_regs    = '0;
    repeat (3) step();
    check("rst.gen_req", gen_req, 0);
    check("rst.cfg_valid", cfg_valid, 0);
    check("rst.frame_err", frame_err, 0);
    check("rst.err_cnt", err_cnt, 0);
    check("rst.byte_cnt", byte_cnt, 0);
    check_regs("rst", '0);
    reset = 1'b0;
    step();

    // A byte while cs is high is ignored.
    send_byte(8'h55);
    check("cs_high.byte_cnt", byte_cnt, 0);
    step();
    check("cs_high.frame_err", frame_err, 0);
    cs = 1'b0;
    step();

    for (int v = 0; v < 8; v++) begin
      send_bytes(vecs[v].f, 0);
      check("tbl.byte_cnt_full", byte_cnt, 8);
      step();
      check("tbl.frame_err", frame_err, vecs[v].err);
      check("tbl.byte_cnt_clr", byte_cnt, 0);
      if (vecs[v].err) bump_err();
      else exp_regs = vecs[v].f;
      check("tbl.err_cnt", err_cnt, exp_err_cnt);
      step();
      check("tbl.frame_err_pulse", frame_err, 0);
      check("tbl.cfg_valid", cfg_valid, !vecs[v].err);
      check_regs("tbl", exp_regs);
      wait_req_drop("tbl.gen_req_cycles", vecs[v].err ? 0 : 4);
      check("tbl.cfg_valid_low", cfg_valid, 0);
      step();
    end

    // Inter-byte timeout fires exactly TO cycles after the last byte.
    send_byte(8'h01); step();
    send_byte(8'h80); step();
    send_byte(8'h05);
    repeat (TO - 1) step();
    check("to.before.frame_err", frame_err, 0);
    check("to.before.byte_cnt", byte_cnt, 3);
    step();
    check("to.frame_err", frame_err, 1);
    check("to.byte_cnt", byte_cnt, 0);
    bump_err();
    check("to.err_cnt", err_cnt, exp_err_cnt);
    step();
    check("to.frame_err_pulse", frame_err, 0);
    send_bytes(fa, 0);
    step(); step();
    check("to.next.cfg_valid", cfg_valid, 1);
    check_regs("to.next", fa);
    wait_req_drop("to.next.gen_req_cycles", 4);
    step();

    // A byte landing on the expiry cycle is accepted.
    send_byte(fd[0]); step();
    send_byte(fd[1]); step();
    send_byte(fd[2]);
    repeat (TO - 1) step();
    send_byte(fd[3]);
    check("to_rdy.frame_err", frame_err, 0);
    check("to_rdy.byte_cnt", byte_cnt, 4);
    step();
    send_bytes(fd, 4);
    step();
    check("to_rdy.frame_err2", frame_err, 0);
    step();
    check("to_rdy.cfg_valid", cfg_valid, 1);
    check_regs("to_rdy", fd);
    wait_req_drop("to_rdy.gen_req_cycles", 4);
    step();

    // cs abort after four bytes, together with a fifth rdy that must be dropped.
    for (int i = 0; i < 4; i++) begin
      send_byte(fb[i]);
      step();
    end
    cs = 1'b1; rdy = 1'b1; data_byte = 8'h99;
    step();
    rdy = 1'b0;
    check("abort.frame_err", frame_err, 1);
    check("abort.byte_cnt", byte_cnt, 0);
    bump_err();
    check("abort.err_cnt", err_cnt, exp_err_cnt);
    send_byte(8'h42);
    check("abort.frame_err_pulse", frame_err, 0);
    check("abort.idle_byte_cnt", byte_cnt, 0);
    step();
    check("abort.err_cnt_once", err_cnt, exp_err_cnt);
    cs = 1'b0;
    step();
    send_bytes(fc, 0);
    step(); step();
    check("abort.next.cfg_valid", cfg_valid, 1);
    check_regs("abort.next", fc);
    wait_req_drop("abort.next.gen_req_cycles", 4);
    repeat (4) step();

    // Pending slot: A committed without ack, B then C arrive, C wins.
    ack_auto = 1'b0;
    ack_man  = 1'b0;
    send_bytes(fa, 0);
    step(); step();
    check("pend.a.cfg_valid", cfg_valid, 1);
    check_regs("pend.a", fa);
    step();
    saw_b = 1'b0;
    send_bytes(fb, 0);
    step(); step();
    check("pend.b.cfg_valid", cfg_valid, 0);
    check("pend.b.frame_err", frame_err, 0);
    check_regs("pend.b", fa);
    send_bytes(fc, 0);
    step(); step();
    check("pend.c.cfg_valid", cfg_valid, 0);
    check("pend.c.gen_req", gen_req, 1);
    check_regs("pend.c", fa);
    ack_man = 1'b1;
    step();
    ack_man = 1'b0;
    check("pend.ack.gen_req", gen_req, 0);
    check("pend.ack.cfg_valid", cfg_valid, 0);
    step();
    check("pend.commit.cfg_valid", cfg_valid, 1);
    check("pend.commit.gen_req", gen_req, 1);
    check_regs("pend.commit", fc);
    step();
    check("pend.commit.cfg_valid_pulse", cfg_valid, 0);
    ack_man = 1'b1;
    step();
    ack_man = 1'b0;
    check("pend.ack2.gen_req", gen_req, 0);
    repeat (3) step();
    check("pend.drained.cfg_valid", cfg_valid, 0);
    check("pend.drained.gen_req", gen_req, 0);
    check("pend.b_never_visible", saw_b, 0);
    ack_auto = 1'b1;
    repeat (4) step();

    // Error counter saturation.
    for (int k = 0; k < 300; k++) begin
      send_bytes(fbad, 0);
      step();
      bump_err();
    end
    step();
    check("sat.err_cnt", err_cnt, 8'hFF);
    check("sat.model", exp_err_cnt, err_cnt);
    check_regs("sat", fc);

    // Reset in the middle of a handshake.
    ack_auto = 1'b0;
    send_bytes(fd, 0);
    step(); step();
    check("rst_hs.gen_req_before", gen_req, 1);
    reset = 1'b1;
    step();
    check("rst_hs.gen_req", gen_req, 0);
    check("rst_hs.cfg_valid", cfg_valid, 0);
    check("rst_hs.err_cnt", err_cnt, 0);
    check("rst_hs.byte_cnt", byte_cnt, 0);
    check_regs("rst_hs", '0);
    reset = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
